uart_rx_fifo: RTL
=================

Name: uart_rx_fifo

Overview:
Parametrised next-generation UART receiver for the peripherals subsystem. Supports configurable data width, bit period, optional parity and a show-ahead receive FIFO. Reports sticky framing, parity and overrun error flags. Sits beside uart_tx on the peripheral bus and drives a host-side pop interface in place of the single-register rx_data/rx_valid pair.

Parameters:
DATA_BITS, 8, data bits per frame, legal 5..9, LSB first
CLKS_PER_BIT, 434, clk_i cycles per bit (50 MHz / 115200), minimum 8
PARITY, 0, 0 = none, 1 = odd, 2 = even
FIFO_DEPTH, 4, receive FIFO entries, power of two, at least 2

Ports:
clk_i  in  1  system clock, all logic on the rising edge
rst_ni  in  1  synchronous, active-low reset
rx_enable  in  1  receiver enable
rx  in  1  serial input, asynchronous, idles high
rd  in  1  pop the head FIFO entry
err_clr  in  1  clear all sticky error flags
rx_data  out  DATA_BITS  head FIFO entry (show-ahead)
rx_valid  out  1  FIFO not empty
fifo_level  out  $clog2(FIFO_DEPTH)+1  number of stored entries
busy  out  1  FSM not in IDLE
frame_err  out  1  sticky: stop bit sampled low
parity_err  out  1  sticky: parity mismatch
overrun_err  out  1  sticky: word dropped because FIFO full

Behaviour:
- One clock; reset is synchronous and active-low.
- Reset: FSM to IDLE, synchroniser flops to 1, FIFO emptied, bit counter 0, all error flags 0. Outputs: rx_valid 0, fifo_level 0, busy 0, rx_data 0.
- rx passes through a 2-flop synchroniser (rx_s). All sampling uses rx_s.
- Bit counter counts down. A sample point is counter==0.
- FSM states:
  - IDLE: if rx_enable && rx_s==0, load CLKS_PER_BIT/2-1, go to START.
  - START: at sample point, if rx_s==1 it is a glitch: go to IDLE, no error. Otherwise load CLKS_PER_BIT-1, go to DATA.
  - DATA: shift the sample in LSB first. After DATA_BITS samples go to PARITY if PARITY!=0, else STOP.
  - PARITY: sample and compare with odd/even parity over the data bits. Record the mismatch, go to STOP.
  - STOP: sample. If 1 and no parity mismatch, push the word and go to IDLE. If 1 with a mismatch, set parity_err, drop the word, go to IDLE. If 0, set frame_err, drop the word, go to WAIT_HIGH.
  - WAIT_HIGH: stay until rx_s==1, then go to IDLE. A break never produces a second frame.
- rx_enable low in any non-IDLE state: abort to IDLE next cycle. The partial word is discarded and no error flag is set.
- FIFO:
  - rx_valid=1 and fifo_level increments on the cycle after the STOP sample point.
  - rx_data shows the head entry combinationally from storage, and reads 0 when empty.
  - rd with rx_valid pops; rd when empty is ignored.
  - Push and pop in the same cycle: both take effect, level unchanged, including when full (no overrun).
  - Push when full without a pop: the word is dropped and overrun_err is set.
  - Pointers wrap modulo FIFO_DEPTH.
- Error flags stay set until err_clr. If a set event and err_clr land in the same cycle, set wins.
- Latency: rx pin edge to FSM reaction is 2 cycles (synchroniser).

Optional Feature:
UART_RX_MAJORITY_EN.
- Defined: every data, start, parity and stop sample is the 2-of-3 majority of rx_s at counter values 2, 1 and 0. A single-cycle glitch does not corrupt a bit.
- Undefined: single sample of rx_s at counter==0.
- Counter timing and all other behaviour are identical in both builds.

Test Plan:
- CLKS_PER_BIT=16, PARITY=0: send 0xA5 8N1 -> one cycle after the stop sample, rx_valid=1, rx_data=0xA5, fifo_level=1. Pulse rd -> rx_valid=0, rx_data=0.
- PARITY=2: send 0x3C with parity bit 1 -> parity_err=1, fifo_level stays 0. Pulse err_clr -> parity_err=0. Resend with parity bit 0 -> 0x3C received.
- Send 0x55 with stop bit 0 and hold rx low 40 cycles -> frame_err=1, busy=1 until rx rises. A following 0x0F frame is received correctly.
- FIFO_DEPTH=4: send 0x01..0x05 with no rd -> fifo_level=4, overrun_err=1. Four pops return 0x01, 0x02, 0x03, 0x04. Pop and push in the same cycle while full -> no overrun.
- rx low for 4 cycles (<8) -> returns to IDLE, no push, no errors. With UART_RX_MAJORITY_EN, a 1-cycle high glitch mid-bit on 0xA5 -> still 0xA5.
- rx_enable dropped during data bit 3 -> busy=0 next cycle, no push, no flag. rst_ni low mid-frame -> all outputs at reset values on the next edge.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// UART receiver: 2-flop synchroniser, start/data/parity/stop FSM, show-ahead receive FIFO, sticky errors.
// Optional build macro UART_RX_MAJORITY_EN: each bit is a 2-of-3 vote of rx_s at counter 2, 1 and 0.
module uart_rx_fifo #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 434,
    parameter int PARITY       = 0,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          rx_enable,
    input  logic                          rx,
    input  logic                          rd,
    input  logic                          err_clr,
    output logic [DATA_BITS-1:0]          rx_data,
    output logic                          rx_valid,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          busy,
    output logic                          frame_err,
    output logic                          parity_err,
    output logic                          overrun_err
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);
    localparam logic [LVL_W-1:0] FULL_LVL  = LVL_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH
    } state_t;

    logic rx_meta;
    logic rx_s;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    logic bit_val;
`ifdef UART_RX_MAJORITY_EN
    logic [1:0] rx_hist;  // rx_s one and two cycles ago, i.e. at counter values 1 and 2

    always_ff @(posedge clk_i) begin
        if (!rst_ni) rx_hist <= 2'b11;
        else         rx_hist <= {rx_hist[0], rx_s};
    end

    assign bit_val = (rx_hist[1] & rx_hist[0]) | (rx_hist[1] & rx_s) | (rx_hist[0] & rx_s);
`else
    assign bit_val = rx_s;
`endif

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shift;
    logic                 par_bad;
    logic                 tick;
    logic                 exp_par;
    logic                 push;

    assign tick    = (cnt == '0);
    assign exp_par = (PARITY == 1) ? ~^shift : ^shift;
    assign push    = rx_enable && (state == S_STOP) && tick && bit_val && !par_bad;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state      <= S_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            par_bad    <= 1'b0;
            busy       <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            // NOTE: the clear is written first so a set later in this block overrides it.
            if (err_clr) begin
                frame_err  <= 1'b0;
                parity_err <= 1'b0;
            end
            if (state != S_IDLE && !rx_enable) begin
                state <= S_IDLE;
                busy  <= 1'b0;
            end else begin
                if (state != S_IDLE && state != S_WAIT_HIGH)
                    cnt <= tick ? FULL_LOAD : cnt - 1'b1;
                case (state)
                    S_IDLE: if (rx_enable && !rx_s) begin
                        cnt     <= HALF_LOAD;
                        bit_idx <= '0;
                        par_bad <= 1'b0;
                        busy    <= 1'b1;
                        state   <= S_START;
                    end
                    S_START: if (tick) begin
                        if (bit_val) begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= S_DATA;
                        end
                    end
                    S_DATA: if (tick) begin
                        shift <= {bit_val, shift[DATA_BITS-1:1]};
                        if (bit_idx == LAST_IDX) begin
                            bit_idx <= '0;
                            state   <= (PARITY != 0) ? S_PARITY : S_STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                    S_PARITY: if (tick) begin
                        par_bad <= (bit_val != exp_par);
                        state   <= S_STOP;
                    end
                    S_STOP: if (tick) begin
                        if (!bit_val) begin
                            frame_err <= 1'b1;
                            state     <= S_WAIT_HIGH;
                        end else begin
                            if (par_bad) parity_err <= 1'b1;
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end
                    end
                    S_WAIT_HIGH: if (rx_s) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [LVL_W-1:0]     level;
    logic                 pop;
    logic                 full;
    logic                 wr_en;

    assign rx_valid   = (level != '0);
    assign full       = (level == FULL_LVL);
    assign pop        = rd && rx_valid;
    assign wr_en      = push && (!full || pop);
    assign rx_data    = rx_valid ? mem[rd_ptr] : '0;
    assign fifo_level = level;

    // NOTE: storage is not reset; rx_data is gated by the level so stale words never reach the port.
    always_ff @(posedge clk_i) begin
        if (wr_en) mem[wr_ptr] <= shift;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level       <= '0;
            overrun_err <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            if (wr_en && !pop)      level <= level + 1'b1;
            else if (pop && !wr_en) level <= level - 1'b1;
            if (push && full && !pop) overrun_err <= 1'b1;
            else if (err_clr)         overrun_err <= 1'b0;
        end
    end

endmodule
